// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the sequential Hack multiplier: state encoding and word width.
package mult16_seq_pkg;

    localparam int HACK_WORD_W = 16;

    // Encoding 2'd3 is never entered; the FSM treats it exactly like IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult16_seq_add16.sv
// Hack add16: WIDTH-bit adder, carry out discarded (modulo 2^WIDTH).
module add16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/mult16_seq.sv
// Sequential shift-and-add multiplier: WIDTH steps per operand pair, result is
// the low WIDTH bits of a*b, delivered on a valid/ready handshake.
module mult16_seq
    import mult16_seq_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_W,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_step;
    logic             w_idle;
    logic             w_accept;
    logic             w_last;

    // Unused encoding 2'd3 decodes as IDLE, so it can accept and recover.
    assign w_idle     = (r_state != BUSY) && (r_state != DONE);
    assign w_accept   = w_idle && in_valid;
    assign w_last     = (r_state == BUSY) && (r_cnt == LAST_CNT);
    assign w_acc_step = r_mplier[0] ? w_sum : r_acc;

    assign in_ready  = w_idle;
    assign out_valid = (r_state == DONE);
    assign out       = r_out;

    add16 #(.WIDTH(WIDTH)) u_step_add (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .o_sum (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = in_valid ? BUSY : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= '0;
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) r_out <= w_acc_step;
        end
    end

endmodule

// File: doc/mult16_seq.md
Name: mult16_seq

Overview:
- Sequential 16-bit shift-and-add multiplier for the Hack datapath.
- Sits directly downstream of add16 and consumes its result: each iteration registers the add16 output as the new partial product.
- Gives the Hack core a hardware multiply. Operands arrive on a valid/ready handshake.
- Result is the low WIDTH bits of a*b. This matches Hack 16-bit wrap-around semantics and is identical for signed and unsigned operands.

Parameters:
- WIDTH, 16, operand and result width; must equal the add16 width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- out  output  WIDTH  low WIDTH bits of a*b.

Behaviour:
- Single clock domain. Asynchronous active-low reset:
  - state=IDLE; acc, mcand, mplier, cnt and out cleared to 0.
  - in_ready=1 once reset is released; out_valid=0.
- States:
  - IDLE -> BUSY when in_valid & in_ready.
  - BUSY -> DONE after the WIDTH-th step.
  - DONE -> IDLE when out_valid & out_ready.
- Output decodes: in_ready = (state==IDLE); out_valid = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- Accept edge: mcand<=a; mplier<=b; acc<=0; cnt<=0.
- BUSY step on each edge:
  - if mplier[0], acc<=add16(acc, mcand); else acc holds.
  - mcand<=mcand<<1, zero-filled, truncated to WIDTH.
  - mplier<=mplier>>1; cnt<=cnt+1.
- Step WIDTH, at cnt==WIDTH-1: perform the step, register the final value in out, go to DONE.
- Latency is fixed with no early termination:
  - accept at edge T0;
  - out_valid high in the cycle after edge T16 (WIDTH=16);
  - 17 cycles from the accept edge to the first possible output handshake.
- All arithmetic is modulo 2^WIDTH. Carry out of add16 and bits shifted out of mcand are discarded.
- Backpressure: in DONE, out and out_valid hold stable indefinitely while out_ready=0.
- in_valid during BUSY or DONE is ignored (in_ready=0); a, b are not sampled. Upstream must hold them.
- No back-to-back overlap:
  - On the DONE->IDLE edge, in_ready is still 0, so no new operands are accepted on that same edge.
  - Minimum initiation interval is WIDTH+2 cycles.
- Reset asserted mid-operation (BUSY or DONE): immediate return to reset values. The partial result is lost and no out_valid is produced.
- out is only meaningful while out_valid=1. It holds its last value in IDLE/BUSY.

Decomposition:
- Shared defs header/package holds:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2; encoding 2'd3 is unreachable and decodes to IDLE;
  - HACK_WORD_W=16.
- One sub-module: the existing add16, instantiated once as the step adder. No other sub-modules.
- Control FSM and datapath registers live in mult16_seq.

Test Plan:
- Reset release, then a=0x0005, b=0x0003 with in_valid -> out_valid after 17 cycles; out=0x000F; in_ready low throughout BUSY/DONE.
- a=0x1234, b=0x5678 -> out=0x0060 (full product 0x06260060 truncated). Repeat with a=0xFFFF, b=0xFFFF -> out=0x0001.
- Zero and identity cases:
  - a=0x0000, b=0xABCD -> out=0x0000;
  - a=0xFFFF, b=0x0001 -> out=0xFFFF;
  - a=0x0001, b=0x8000 -> out=0x8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out stable. A new in_valid with different a, b during this window is not accepted. Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Reset mid-BUSY: assert rst_n=0 at step 8 of 0x1234*0x5678 -> out_valid=0, in_ready=1 after release. A following 0x0002*0x0003 yields 0x0006 with no stale data.
- Random regression: 1000 random a, b pairs with random out_ready stalls -> out == (a*b) & 0xFFFF. Exactly one output per accepted input, in order.
